axi_addr_router: RTL and testbench
==================================

AXI_ADDR_ROUTER -- requirements
Module: axi_addr_router

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 Parameter ID_WIDTH, default 4, transaction ID width.
REQ-003 Parameter SLAVES, default 2, number of decoded slave regions, minimum 2.
REQ-004 Parameter MAX_OUTSTANDING, default 4, maximum issued-but-uncompleted transactions, minimum 1.
REQ-005 Parameter address_map_base [0:SLAVES-1], default {'h0000_0000,'h1000_0000}, inclusive region start addresses.
REQ-006 Parameter address_map_end [0:SLAVES-1], default {'h0fff_ffff,'h1fff_ffff}, inclusive region end addresses.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 s_valid  input  1  upstream address request valid.
REQ-010 s_ready  output  1  router accepts the request.
REQ-011 s_addr  input  ADDR_WIDTH  request address.
REQ-012 s_id  input  ID_WIDTH  request ID.
REQ-013 m_valid  output  1  routed request valid.
REQ-014 m_ready  input  1  downstream accepts the routed request.
REQ-015 m_addr / m_id  output  ADDR_WIDTH / ID_WIDTH  registered copies of s_addr / s_id.
REQ-016 m_dest  output  $clog2(SLAVES)  destination slave index.
REQ-017 m_decerr  output  1  address hit no region.
REQ-018 done  input  1  one-cycle pulse per completed transaction (last response handshake).
REQ-019 outstanding  output  $clog2(MAX_OUTSTANDING+1)  current outstanding count.

Function
REQ-020 Decode: region i hits when address_map_base[i] <= s_addr <= address_map_end[i], comparisons unsigned; on multiple hits, lowest index wins.
REQ-021 One register stage: s_valid && s_ready loads addr, id, decoded dest and decerr; the request is presented on m_* in the following cycle (latency 1).
REQ-022 s_ready = !stage_full || (m_valid && m_ready); back-to-back acceptance at full throughput when downstream is ready and issue is permitted.
REQ-023 State machine: IDLE (count 0), ACTIVE (0 < count < MAX_OUTSTANDING, locked to lock_dest), FULL (count == MAX_OUTSTANDING).
REQ-024 Issue permitted in IDLE; in ACTIVE only if staged dest == lock_dest and staged decerr == lock_decerr; never in FULL.
REQ-025 m_valid = stage_full && issue permitted; m_valid, once high, holds with stable m_* until m_ready.
REQ-026 Issue handshake (m_valid && m_ready) increments count and loads lock_dest/lock_decerr; done decrements count.
REQ-027 Issue and done in the same cycle leave count unchanged; lock state updates to the issued request.
REQ-028 done while count == 0 is ignored; count never wraps below 0 or above MAX_OUTSTANDING.
REQ-029 Transitions: IDLE->ACTIVE on issue (or ->FULL when MAX_OUTSTANDING == 1); ACTIVE->FULL when count reaches MAX; FULL->ACTIVE and ACTIVE->IDLE on done-driven decrement.
REQ-030 A staged request to a different destination stalls (m_valid low, s_ready low) until the count returns to 0.

Reset
REQ-031 On rst: stage_full 0, m_valid 0, s_ready 1, m_addr 0, m_id 0, m_dest 0, m_decerr 0, outstanding 0, state IDLE, lock_dest 0, lock_decerr 0.
REQ-032 Reset asserted mid-transaction discards staged and outstanding requests immediately; no done is required afterwards.

Configuration
REQ-033 Macro AXI_ADDR_ROUTER_DECERR_EN defined: an unmapped address sets m_decerr 1 with m_dest 0, and is issued and counted like any other request (the downstream error slave returns its done).
REQ-034 Macro undefined: m_decerr is tied 0 and an unmapped address routes to m_dest 0.

Verification
REQ-035 Defaults; s_addr 'h1000_0010 with s_valid held and m_ready 1 -> m_valid next cycle, m_dest 1, m_decerr 0, outstanding 1.
REQ-036 Two requests, to 'h0000_0100 then 'h1000_0000, with no done -> second stalls with m_valid 0; a done pulse brings outstanding to 0 and the second issues with m_dest 1.
REQ-037 Four issues to slave 0 and no done -> outstanding 4, state FULL, fifth request stalls; one done -> fifth issues, outstanding stays 4.
REQ-038 Issue and done in the same cycle with outstanding 2 -> outstanding stays 2; done with outstanding 0 -> outstanding stays 0.
REQ-039 With AXI_ADDR_ROUTER_DECERR_EN, s_addr 'h2000_0000 -> m_decerr 1, m_dest 0; without the macro -> m_decerr 0, m_dest 0.
REQ-040 rst asserted asynchronously with outstanding 3 and stage full -> all outputs take their reset values before the next clk edge, and s_ready is 1.

Source files
------------

// File: rtl/axi_addr_router.sv
// axi_addr_router: decodes an address request to a slave region and
// issues it through one register stage, with an outstanding-transaction limit.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready upstream request handshake; s_addr, s_id request fields
//   m_valid/m_ready routed request handshake; m_addr, m_id registered fields
//   m_dest          destination slave index
//   m_decerr        request hit no region
//   done            one-cycle pulse per completed transaction
//   outstanding     issued-but-uncompleted transaction count
//
// Option macro AXI_ADDR_ROUTER_DECERR_EN: an unmapped address is flagged
// with m_decerr=1 and m_dest=0. If the macro is undefined, m_decerr stays 0
// and an unmapped address goes to slave 0.
module axi_addr_router #(
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int SLAVES          = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter logic [ADDR_WIDTH-1:0] address_map_base [0:SLAVES-1] =
      '{'h0000_0000, 'h1000_0000},
   parameter logic [ADDR_WIDTH-1:0] address_map_end [0:SLAVES-1] =
      '{'h0fff_ffff, 'h1fff_ffff},
   localparam int DEST_W = $clog2(SLAVES),
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [ADDR_WIDTH-1:0] s_addr,
   input  logic [ID_WIDTH-1:0]   s_id,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [ID_WIDTH-1:0]   m_id,
   output logic [DEST_W-1:0]     m_dest,
   output logic                  m_decerr,
   input  logic                  done,
   output logic [CNT_W-1:0]      outstanding
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_FULL   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nx;
   logic              stage_full;
   logic [DEST_W-1:0] lock_dest;
   logic              lock_decerr;

   logic [DEST_W-1:0] dec_dest;
   logic              dec_err;

   logic issue_ok;
   logic s_hs;
   logic m_hs;
   logic done_eff;

   // Walk regions from highest to lowest so the lowest matching index
   // is the one left in dec_dest.
   always_comb begin
      dec_dest = '0;
`ifdef AXI_ADDR_ROUTER_DECERR_EN
      dec_err  = 1'b1;
`else
      dec_err  = 1'b0;
`endif
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if (s_addr >= address_map_base[i] &&
             s_addr <= address_map_end[i]) begin
            dec_dest = DEST_W'(i);
            dec_err  = 1'b0;
         end
      end
   end

   // While transactions are in flight the router stays locked to one
   // destination so responses from different slaves cannot reorder.
   always_comb begin
      issue_ok = 1'b0;
      unique case (state)
         ST_IDLE:   issue_ok = 1'b1;
         ST_ACTIVE: issue_ok = (m_dest == lock_dest) &&
                               (m_decerr == lock_decerr);
         default:   issue_ok = 1'b0;
      endcase
   end

   assign m_valid  = stage_full && issue_ok;
   assign m_hs     = m_valid && m_ready;
   assign s_ready  = !stage_full || m_hs;
   assign s_hs     = s_valid && s_ready;
   assign done_eff = done && (count != '0);

   always_comb begin
      count_nx = count;
      unique case ({m_hs, done_eff})
         2'b10:   count_nx = count + 1'b1;
         2'b01:   count_nx = count - 1'b1;
         default: count_nx = count;
      endcase
   end

   always_comb begin
      if (count_nx == '0) begin
         state_nx = ST_IDLE;
      end else if (count_nx == CNT_MAX) begin
         state_nx = ST_FULL;
      end else begin
         state_nx = ST_ACTIVE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_full  <= 1'b0;
         m_addr      <= '0;
         m_id        <= '0;
         m_dest      <= '0;
         m_decerr    <= 1'b0;
         count       <= '0;
         state       <= ST_IDLE;
         lock_dest   <= '0;
         lock_decerr <= 1'b0;
      end else begin
         if (s_hs) begin
            stage_full <= 1'b1;
            m_addr     <= s_addr;
            m_id       <= s_id;
            m_dest     <= dec_dest;
            m_decerr   <= dec_err;
         end else if (m_hs) begin
            stage_full <= 1'b0;
         end
         if (m_hs) begin
            lock_dest   <= m_dest;
            lock_decerr <= m_decerr;
         end
         count <= count_nx;
         state <= state_nx;
      end
   end

   assign outstanding = count;

endmodule

// File: tb/tb_axi_addr_router.sv
// tb_axi_addr_router: directed scoreboard bench for axi_addr_router.
// Issued requests are checked by a monitor against a queue of expectations.
module tb_axi_addr_router;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_addr;
   logic [3:0]  s_id;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_addr;
   logic [3:0]  m_id;
   logic [0:0]  m_dest;
   logic        m_decerr;
   logic        done;
   logic [2:0]  outstanding;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [0:0]  dest;
      logic        decerr;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

`ifdef AXI_ADDR_ROUTER_DECERR_EN
   localparam logic UNMAPPED_ERR = 1'b1;
`else
   localparam logic UNMAPPED_ERR = 1'b0;
`endif

   axi_addr_router dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_addr      (s_addr),
      .s_id        (s_id),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_addr      (m_addr),
      .m_id        (m_id),
      .m_dest      (m_dest),
      .m_decerr    (m_decerr),
      .done        (done),
      .outstanding (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every issue handshake is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL issue: got addr %0h with nothing expected",
                     m_addr);
         end else begin
            chk("issue", {m_addr, m_id, m_dest, m_decerr},
                64'(sb.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      tick(1);
      done = 1'b0;
   endtask

   // Present one request until accepted, then queue its expectation.
   task automatic send(input logic [31:0] a, input logic [3:0] id,
                       input logic d, input logic e);
      bit ok;
      ok = 0;
      s_valid = 1'b1;
      s_addr  = a;
      s_id    = id;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1;
            sb.push_back('{addr: a, id: id, dest: d, decerr: e});
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL accept: addr %0h not accepted in 50 cycles", a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_addr  = '0;
      s_id    = '0;
      m_ready = 1'b1;
      done    = 1'b0;
      tick(2);

      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_outst", outstanding, 0);
      chk("rst_m_fields", {m_addr, m_id, m_dest, m_decerr}, 0);
      rst = 1'b0;
      tick(1);

      // Single request to slave 1, latency 1.
      send(32'h1000_0010, 4'h3, 1'b1, 1'b0);
      chk("lat1_m_valid", m_valid, 1);
      tick(1);
      chk("lat1_outst", outstanding, 1);
      pulse_done();
      chk("lat1_drain", outstanding, 0);

      // Destination switch stalls until count is 0.
      send(32'h0000_0100, 4'h1, 1'b0, 1'b0);
      tick(1);
      chk("sw_outst1", outstanding, 1);
      send(32'h1000_0000, 4'h2, 1'b1, 1'b0);
      tick(2);
      chk("sw_stall_mv", m_valid, 0);
      chk("sw_stall_sr", s_ready, 0);
      chk("sw_stall_out", outstanding, 1);
      pulse_done();
      chk("sw_release_mv", m_valid, 1);
      tick(1);
      chk("sw_issued_out", outstanding, 1);
      pulse_done();
      chk("sw_drain", outstanding, 0);

      // Fill to the limit, fifth request waits for a done.
      send(32'h0000_0200, 4'h4, 1'b0, 1'b0);
      send(32'h0000_0300, 4'h5, 1'b0, 1'b0);
      send(32'h0000_0400, 4'h6, 1'b0, 1'b0);
      send(32'h0fff_ffff, 4'h7, 1'b0, 1'b0);
      send(32'h0000_0500, 4'h8, 1'b0, 1'b0);
      chk("full_outst", outstanding, 4);
      tick(2);
      chk("full_stall_mv", m_valid, 0);
      chk("full_stall_sr", s_ready, 0);
      pulse_done();
      chk("full_release", m_valid, 1);
      tick(1);
      chk("full_refill", outstanding, 4);

      // Issue and done in the same cycle at count 2.
      pulse_done();
      pulse_done();
      chk("same_pre", outstanding, 2);
      send(32'h0000_0600, 4'h9, 1'b0, 1'b0);
      chk("same_mv", m_valid, 1);
      pulse_done();
      chk("same_outst", outstanding, 2);
      pulse_done();
      pulse_done();
      chk("drain_zero", outstanding, 0);
      pulse_done();
      chk("done_at_zero", outstanding, 0);

      // Unmapped address.
      send(32'h2000_0000, 4'ha, 1'b0, UNMAPPED_ERR);
      tick(1);
      chk("unmap_outst", outstanding, 1);
      pulse_done();
      chk("unmap_drain", outstanding, 0);

      // Asynchronous reset with three outstanding and the stage full.
      send(32'h0000_0700, 4'hb, 1'b0, 1'b0);
      send(32'h0000_0800, 4'hc, 1'b0, 1'b0);
      send(32'h0000_0900, 4'hd, 1'b0, 1'b0);
      send(32'h1000_0020, 4'he, 1'b1, 1'b0);
      chk("ar_outst3", outstanding, 3);
      chk("ar_stalled", m_valid, 0);
      chk("ar_pending", sb.size(), 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_s_ready", s_ready, 1);
      chk("ar_m_valid", m_valid, 0);
      chk("ar_outst", outstanding, 0);
      chk("ar_m_fields", {m_addr, m_id, m_dest, m_decerr}, 0);
      sb.delete();
      tick(1);
      rst = 1'b0;

      // Normal operation resumes; upper boundary of slave 1.
      send(32'h1fff_ffff, 4'hf, 1'b1, 1'b0);
      tick(1);
      chk("post_rst_out", outstanding, 1);
      pulse_done();
      chk("post_rst_drain", outstanding, 0);
      tick(2);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
